// File: rtl/adder_pipe_nbit_if.sv
// Operand/result bundle for adder_pipe_nbit; the pipeline is the slave, the issuer the master.
// Latency: none, this is only wiring.
// Backpressure: none; there is no ready signal, and the issuer may present one operation per cycle.
// Optional macro ADDER_ZERO_FLAG_EN adds the registered 'zero' result flag.
interface adder_pipe_nbit_if #(
  parameter int BIT_WIDTH = 16
);
  logic                 clear;
  logic                 valid_in;
  logic [BIT_WIDTH-1:0] a;
  logic [BIT_WIDTH-1:0] b;
  logic                 carry_in;
  logic                 signed_mode;
  logic                 valid_out;
  logic [BIT_WIDTH-1:0] sum;
  logic                 overflow;
`ifdef ADDER_ZERO_FLAG_EN
  logic                 zero;

  modport master (
    output clear, valid_in, a, b, carry_in, signed_mode,
    input  valid_out, sum, overflow, zero
  );
  modport slave (
    input  clear, valid_in, a, b, carry_in, signed_mode,
    output valid_out, sum, overflow, zero
  );
`else
  modport master (
    output clear, valid_in, a, b, carry_in, signed_mode,
    input  valid_out, sum, overflow
  );
  modport slave (
    input  clear, valid_in, a, b, carry_in, signed_mode,
    output valid_out, sum, overflow
  );
`endif
endinterface

// File: rtl/adder_pipe_nbit.sv
// Carry-chained pipelined adder: each stage adds one CHUNK-wide slice with the carry registered by the previous stage.
// Latency: NUM_STAGES cycles from the valid_in sample to the valid_out pulse.
// Backpressure: none; one operation is accepted per cycle. 'clear' kills everything in flight.
// Optional macro ADDER_ZERO_FLAG_EN adds a registered 'zero' flag that is updated together with sum.
module adder_pipe_nbit #(
  parameter int BIT_WIDTH  = 16,
  parameter int NUM_STAGES = 4
) (
  input logic              clk,
  input logic              n_rst,
  adder_pipe_nbit_if.slave bus
);

  localparam int CHUNK = BIT_WIDTH / NUM_STAGES;

  // Inputs to stage k. Stage 0 takes the bus directly, and later stages take the
  // previous stage's registers. Operands travel full width (skew), and the sum slices
  // completed so far accumulate in s_in (deskew). As a result, the whole result
  // leaves the pipeline in one cycle.
  logic [BIT_WIDTH-1:0] a_in   [NUM_STAGES];
  logic [BIT_WIDTH-1:0] b_in   [NUM_STAGES];
  logic [BIT_WIDTH-1:0] s_in   [NUM_STAGES];
  logic                 vld_in [NUM_STAGES];
  logic                 sm_in  [NUM_STAGES];
  logic                 cy_in  [NUM_STAGES];

  // Output registers. These are written only by the last stage.
  logic                 vout_q;
  logic [BIT_WIDTH-1:0] sum_q;
  logic                 ovf_q;
`ifdef ADDER_ZERO_FLAG_EN
  logic                 zero_q;
`endif

  assign a_in[0]   = bus.a;
  assign b_in[0]   = bus.b;
  assign s_in[0]   = '0;
  assign vld_in[0] = bus.valid_in;
  assign sm_in[0]  = bus.signed_mode;
  assign cy_in[0]  = bus.carry_in;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [CHUNK:0]       add_w;
    logic [BIT_WIDTH-1:0] s_d;

    // Add this stage's slice and merge it into the partial sum.
    always_comb begin
      add_w = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
            + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
            + {{CHUNK{1'b0}}, cy_in[k]};
      s_d = s_in[k];
      s_d[k*CHUNK +: CHUNK] = add_w[CHUNK-1:0];
    end

    if (k < NUM_STAGES - 1) begin : g_mid
      logic                 vld_q;
      logic                 sm_q;
      logic                 cy_q;
      logic [BIT_WIDTH-1:0] a_q;
      logic [BIT_WIDTH-1:0] b_q;
      logic [BIT_WIDTH-1:0] s_q;

      // Stage register. 'clear' kills the valid bit but leaves the data alone.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          vld_q <= 1'b0;
          sm_q  <= 1'b0;
          cy_q  <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          s_q   <= '0;
        end else begin
          vld_q <= vld_in[k] & ~bus.clear;
          sm_q  <= sm_in[k];
          cy_q  <= add_w[CHUNK];
          a_q   <= a_in[k];
          b_q   <= b_in[k];
          s_q   <= s_d;
        end
      end

      assign a_in[k+1]   = a_q;
      assign b_in[k+1]   = b_q;
      assign s_in[k+1]   = s_d_pass(s_q);
      assign vld_in[k+1] = vld_q;
      assign sm_in[k+1]  = sm_q;
      assign cy_in[k+1]  = cy_q;
    end else begin : g_last
      logic fire;
      logic ovf_d;

      // Signed overflow: both operands have the same sign and the sum's sign differs.
      // This equals carry-into-MSB XOR carry-out-of-MSB, and it works even when CHUNK is 1.
      always_comb begin
        fire  = vld_in[k] & ~bus.clear;
        ovf_d = sm_in[k]
              ? ((a_in[k][BIT_WIDTH-1] == b_in[k][BIT_WIDTH-1]) &&
                 (s_d[BIT_WIDTH-1] != a_in[k][BIT_WIDTH-1]))
              : add_w[CHUNK];
      end

      // Output register. The result changes only when a live operation completes.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          vout_q <= 1'b0;
          sum_q  <= '0;
          ovf_q  <= 1'b0;
`ifdef ADDER_ZERO_FLAG_EN
          zero_q <= 1'b0;
`endif
        end else begin
          vout_q <= fire;
          if (fire) begin
            sum_q <= s_d;
            ovf_q <= ovf_d;
`ifdef ADDER_ZERO_FLAG_EN
            zero_q <= (s_d == '0);
`endif
          end
        end
      end
    end
  end

  // Identity helper. It keeps the partial-sum hand-off between stages explicit.
  function automatic logic [BIT_WIDTH-1:0] s_d_pass(input logic [BIT_WIDTH-1:0] v);
    return v;
  endfunction

  assign bus.valid_out = vout_q;
  assign bus.sum       = sum_q;
  assign bus.overflow  = ovf_q;
`ifdef ADDER_ZERO_FLAG_EN
  assign bus.zero      = zero_q;
`endif

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Directed bench for adder_pipe_nbit with BIT_WIDTH=16 and NUM_STAGES=4.
// Inputs are driven and outputs are sampled on the falling clock edge.
// The 'zero' flag is checked when ADDER_ZERO_FLAG_EN is defined.
module tb_adder_pipe_nbit;

  logic clk;
  logic n_rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  adder_pipe_nbit_if #(.BIT_WIDTH(16)) bus ();

  adder_pipe_nbit #(.BIT_WIDTH(16), .NUM_STAGES(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_vo(input string tag, input logic exp_vo);
    n_chk++;
    assert (bus.valid_out === exp_vo) else begin
      n_fail++;
      $error("FAIL %s valid_out got %0b want %0b", tag, bus.valid_out, exp_vo);
    end
  endtask

  task automatic chk(input string tag, input logic exp_vo, input logic [15:0] exp_s, input logic exp_ov);
    chk_vo(tag, exp_vo);
    n_chk++;
    assert (bus.sum === exp_s) else begin
      n_fail++;
      $error("FAIL %s sum got %04h want %04h", tag, bus.sum, exp_s);
    end
    n_chk++;
    assert (bus.overflow === exp_ov) else begin
      n_fail++;
      $error("FAIL %s overflow got %0b want %0b", tag, bus.overflow, exp_ov);
    end
`ifdef ADDER_ZERO_FLAG_EN
    n_chk++;
    assert (bus.zero === (exp_s == 16'h0000)) else begin
      n_fail++;
      $error("FAIL %s zero got %0b want %0b", tag, bus.zero, (exp_s == 16'h0000));
    end
`endif
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sm);
    bus.valid_in    = 1'b1;
    bus.a           = a;
    bus.b           = b;
    bus.carry_in    = cin;
    bus.signed_mode = sm;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Issue one operation. The pulse must be absent after 3 edges and present after 4.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sm,
                        input logic [15:0] exp_s, input logic exp_ov);
    drive(a, b, cin, sm);
    wait_neg(1);
    bus.valid_in = 1'b0;
    wait_neg(2);
    chk_vo({tag, "_early"}, 1'b0);
    wait_neg(1);
    chk(tag, 1'b1, exp_s, exp_ov);
  endtask

  initial begin
    n_rst           = 1'b1;
    bus.clear       = 1'b0;
    bus.valid_in    = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.carry_in    = 1'b0;
    bus.signed_mode = 1'b0;

    // Asynchronous reset is applied before any clock edge.
    #2 n_rst = 1'b0;
    #1 chk("reset", 1'b0, 16'h0000, 1'b0);
    wait_neg(2);
    n_rst = 1'b1;

    // Unsigned wrap-around.
    run_op("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    wait_neg(1);
    chk("hold_after_pulse", 1'b0, 16'h0000, 1'b1);

    // Four operations issued back to back.
    drive(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_neg(1);
    drive(16'h0002, 16'h0002, 1'b0, 1'b0);
    wait_neg(1);
    drive(16'h00FF, 16'h0001, 1'b1, 1'b0);
    wait_neg(1);
    drive(16'h8000, 16'h8000, 1'b0, 1'b0);
    wait_neg(1);
    bus.valid_in = 1'b0;
    chk("b2b_0", 1'b1, 16'h0002, 1'b0);
    wait_neg(1);
    chk("b2b_1", 1'b1, 16'h0004, 1'b0);
    wait_neg(1);
    chk("b2b_2", 1'b1, 16'h0101, 1'b0);
    wait_neg(1);
    chk("b2b_3", 1'b1, 16'h0000, 1'b1);
    wait_neg(1);
    chk("b2b_idle", 1'b0, 16'h0000, 1'b1);

    // Signed versus unsigned overflow.
    run_op("7fff_s", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1);
    run_op("7fff_u", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0);
    run_op("m1m1_s", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_op("m1m1_u", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1);
    run_op("neg_s",  16'h8000, 16'hFFFF, 1'b0, 1'b1, 16'h7FFF, 1'b1);
    // Carry-in ripples through three chunk boundaries.
    run_op("ripple", 16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0);

    // 'clear' is sampled two edges after the issue, so the operation never emerges.
    drive(16'h1234, 16'h1111, 1'b0, 1'b0);
    wait_neg(1);
    bus.valid_in = 1'b0;
    wait_neg(1);
    bus.clear = 1'b1;
    wait_neg(1);
    bus.clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("clear_flush", 1'b0, 16'h1000, 1'b0);
      wait_neg(1);
    end

    // 'clear' together with valid_in discards the new operation.
    drive(16'h0001, 16'h0001, 1'b0, 1'b0);
    bus.clear = 1'b1;
    wait_neg(1);
    bus.valid_in = 1'b0;
    bus.clear    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("clear_wins", 1'b0, 16'h1000, 1'b0);
      wait_neg(1);
    end

    run_op("post_clear", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0);

    // Reset is dropped one cycle after an issue.
    drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    wait_neg(1);
    bus.valid_in = 1'b0;
    n_rst = 1'b0;
    #1 chk("rst_mid", 1'b0, 16'h0000, 1'b0);
    wait_neg(2);
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("rst_no_pulse", 1'b0, 16'h0000, 1'b0);
      wait_neg(1);
    end

    // An operation issued straight after reset release is accepted.
    run_op("post_rst", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_pipe_nbit.md
ADDER_PIPE_NBIT -- requirements
Module: adder_pipe_nbit

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter NUM_STAGES, default 4, number of pipeline stages; BIT_WIDTH SHALL be an integer multiple of NUM_STAGES, and CHUNK = BIT_WIDTH/NUM_STAGES.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); n_rst input 1 (active-low asynchronous reset).
REQ-004 clear  input  1  synchronous flush of all in-flight operations.
REQ-005 valid_in  input  1  a, b, carry_in, signed_mode are sampled this cycle.
REQ-006 a, b  input  BIT_WIDTH each  operands.
REQ-007 carry_in  input  1  carry into bit 0.
REQ-008 signed_mode  input  1  1 = two's-complement overflow, 0 = unsigned overflow.
REQ-009 valid_out  output  1  one-cycle pulse; sum/overflow hold a new result.
REQ-010 sum  output  BIT_WIDTH  registered result, low BIT_WIDTH bits of a+b+carry_in.
REQ-011 overflow  output  1  registered overflow flag for sum.

Function
REQ-012 SHALL add CHUNK bits per stage: stage k adds bits [k*CHUNK +: CHUNK] with the registered carry from stage k-1 (stage 0 uses carry_in).
REQ-013 SHALL skew unprocessed operand slices and deskew completed sum slices with registers so all slices of one operation appear on sum together.
REQ-014 Latency SHALL be exactly NUM_STAGES cycles: valid_in high at edge N -> valid_out high after edge N+NUM_STAGES.
REQ-015 SHALL accept a new operation every cycle (throughput 1/cycle, no backpressure); results SHALL leave in issue order.
REQ-016 A valid bit and the sampled signed_mode SHALL travel with each operation; bubbles (valid_in low) SHALL produce no valid_out pulse.
REQ-017 Unsigned mode: overflow SHALL equal the carry out of bit BIT_WIDTH-1.
REQ-018 Signed mode: overflow SHALL equal carry into MSB XOR carry out of MSB.
REQ-019 sum and overflow SHALL update only on a valid_out cycle and hold the last result otherwise.
REQ-020 clear high SHALL zero every in-flight valid bit at the next edge; valid_out SHALL be low the cycle after, and sum/overflow SHALL hold.
REQ-021 clear and valid_in high together: the new operation SHALL be discarded (clear wins).
REQ-022 NUM_STAGES = 1: a single registered full-width add, latency 1.

Reset
REQ-023 n_rst low SHALL immediately, without a clock, force valid_out=0, sum=0, overflow=0 and clear all pipeline valid bits, carries and slice registers.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL emerge after release.
REQ-025 After n_rst rises, the first valid_in SHALL be accepted at the next rising edge.

Configuration
REQ-026 With macro ADDER_ZERO_FLAG_EN defined, SHALL add output zero (1 bit), registered with sum, high when the emitted sum equals 0, reset 0, holding otherwise.
REQ-027 Without ADDER_ZERO_FLAG_EN, the zero port and its logic SHALL be absent; all other behaviour identical.

Verification (BIT_WIDTH=16, NUM_STAGES=4)
REQ-028 a=0xFFFF, b=0x0001, carry_in=0, signed_mode=0 -> 4 cycles later valid_out=1, sum=0x0000, overflow=1 (zero=1 if enabled).
REQ-029 a=0x7FFF, b=0x0001, signed_mode=1 -> sum=0x8000, overflow=1; same operands with signed_mode=0 -> overflow=0.
REQ-030 Four back-to-back issues (1+1, 2+2, 0x00FF+0x0001 with carry_in=1, 0x8000+0x8000 unsigned) -> four consecutive valid_out pulses: 0x0002, 0x0004, 0x0101, 0x0000 with overflow=1 on the last.
REQ-031 Issue 0x1234+0x1111, assert clear 2 cycles later -> no valid_out pulse; sum keeps its previous value.
REQ-032 Issue 0x0F0F+0x0101, drop n_rst 1 cycle later -> sum=0, overflow=0, valid_out=0 immediately and no pulse after release.
